// File: rtl/seg7_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the 7-segment scan controller.
//   SEG_OFF          : segment bus value with every segment dark (active-low)
//   state_t          : scan FSM states OFF / BLANK / SHOW
//   GLYPH_0..GLYPH_F : active-low {a,b,c,d,e,f,g} patterns for each hex nibble
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0000010;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Bundles the value/control inputs and the display pin outputs of the scan
// controller.
//   enable, load, value, dp_in, blank_lz : producer -> controller
//   an, seg, dp, frame_start             : controller -> board pins / observer
// master = producer side, slave = controller side.
// -----------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic                enable;
  logic                load;
  logic [4*NDIG-1:0]   value;
  logic [NDIG-1:0]     dp_in;
  logic                blank_lz;
  logic [NDIG-1:0]     an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_start;

  modport master (
    output enable, load, value, dp_in, blank_lz,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  enable, load, value, dp_in, blank_lz,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to active-low 7-segment decoder.
//   i_nib : 4-bit hex digit
//   o_seg : {a,b,c,d,e,f,g}, active-low
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Glyph lookup
  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'h0:    o_seg = GLYPH_0;
      4'h1:    o_seg = GLYPH_1;
      4'h2:    o_seg = GLYPH_2;
      4'h3:    o_seg = GLYPH_3;
      4'h4:    o_seg = GLYPH_4;
      4'h5:    o_seg = GLYPH_5;
      4'h6:    o_seg = GLYPH_6;
      4'h7:    o_seg = GLYPH_7;
      4'h8:    o_seg = GLYPH_8;
      4'h9:    o_seg = GLYPH_9;
      4'hA:    o_seg = GLYPH_A;
      4'hB:    o_seg = GLYPH_B;
      4'hC:    o_seg = GLYPH_C;
      4'hD:    o_seg = GLYPH_D;
      4'hE:    o_seg = GLYPH_E;
      4'hF:    o_seg = GLYPH_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for an NDIG-digit common-anode display.
// Captures value/dp_in into a pending buffer, commits it to the display buffer
// only at the start of a frame (or immediately while OFF), and walks the digits
// through BLANK (dark guard) and SHOW (lit) slots.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seg7_scan_ctrl_if (inputs + registered pins)
// Parameters: NDIG digits, DIV lit cycles per slot, DEAD dark cycles between.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 1000,
  parameter int DEAD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int MAXV = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = $clog2((MAXV > 2) ? MAXV : 2);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD > 0) ? (DEAD - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*NDIG-1:0]   r_pend_val;
  logic [NDIG-1:0]     r_pend_dp;
  logic                r_pend_vld;
  logic [4*NDIG-1:0]   r_disp_val;
  logic [NDIG-1:0]     r_disp_dp;
  logic [NDIG-1:0]     r_an;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                r_frame_start;

  state_t              w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic                w_enter_show;
  logic                w_frame_begin;
  logic                w_commit;
  logic [4*NDIG-1:0]   w_disp_val_nxt;
  logic [NDIG-1:0]     w_disp_dp_nxt;
  logic [NDIG-1:0]     w_lz_dark;
  logic                w_zero_run;
  logic [3:0]          w_nib;
  logic [6:0]          w_glyph;
  logic [NDIG-1:0]     w_an_nxt;
  logic [6:0]          w_seg_nxt;
  logic                w_dp_nxt;

  // Next state, slot counter and digit index
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_enter_show = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = OFF;
      w_cnt_nxt   = CW'(0);
      w_idx_nxt   = IW'(0);
    end else begin
      case (r_state)
        OFF: begin
          w_cnt_nxt = CW'(0);
          w_idx_nxt = IW'(0);
          // With no dead time there is no BLANK state at all
          if (DEAD == 0) begin
            w_state_nxt  = SHOW;
            w_enter_show = 1'b1;
          end else begin
            w_state_nxt = BLANK;
          end
        end
        BLANK: begin
          if (r_cnt == DEAD_LAST) begin
            w_state_nxt  = SHOW;
            w_cnt_nxt    = CW'(0);
            w_enter_show = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        SHOW: begin
          if (r_cnt == DIV_LAST) begin
            w_cnt_nxt = CW'(0);
            w_idx_nxt = (r_idx == IDX_LAST) ? IW'(0) : (r_idx + IW'(1));
            if (DEAD == 0) begin
              w_state_nxt  = SHOW;
              w_enter_show = 1'b1;
            end else begin
              w_state_nxt = BLANK;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = OFF;
          w_cnt_nxt   = CW'(0);
          w_idx_nxt   = IW'(0);
        end
      endcase
    end
  end

  assign w_frame_begin = w_enter_show && (w_idx_nxt == IW'(0));
  // Pending data lands only on a frame boundary so a frame never mixes values
  assign w_commit      = r_pend_vld && (w_frame_begin || (r_state == OFF));

  // Display buffer as seen by the outputs of the upcoming cycle
  always_comb begin
    if (w_commit) begin
      w_disp_val_nxt = r_pend_val;
      w_disp_dp_nxt  = r_pend_dp;
    end else begin
      w_disp_val_nxt = r_disp_val;
      w_disp_dp_nxt  = r_disp_dp;
    end
  end

  // Leading-zero mask: scan from the top digit while the run of zeros holds
  always_comb begin
    w_lz_dark  = {NDIG{1'b0}};
    w_zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_zero_run   = w_zero_run & (w_disp_val_nxt[4*i +: 4] == 4'h0);
      w_lz_dark[i] = bus.blank_lz & w_zero_run & (i != 0);
    end
  end

  assign w_nib = w_disp_val_nxt[{w_idx_nxt, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  // Pin values for the upcoming cycle; anything but a visible SHOW is dark
  always_comb begin
    w_an_nxt  = {NDIG{1'b1}};
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if ((w_state_nxt == SHOW) && !w_lz_dark[w_idx_nxt]) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
      w_seg_nxt           = w_glyph;
      w_dp_nxt            = ~w_disp_dp_nxt[w_idx_nxt];
    end else begin
      w_an_nxt  = {NDIG{1'b1}};
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = 1'b1;
    end
  end

  // Scan FSM, counters and registered display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= OFF;
      r_cnt         <= CW'(0);
      r_idx         <= IW'(0);
      r_an          <= {NDIG{1'b1}};
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_an          <= w_an_nxt;
      r_seg         <= w_seg_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_start <= w_frame_begin;
    end
  end

  // Pending and display buffers; a load on a commit edge waits for next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val <= {(4*NDIG){1'b0}};
      r_pend_dp  <= {NDIG{1'b0}};
      r_pend_vld <= 1'b0;
      r_disp_val <= {(4*NDIG){1'b0}};
      r_disp_dp  <= {NDIG{1'b0}};
    end else begin
      r_disp_val <= w_disp_val_nxt;
      r_disp_dp  <= w_disp_dp_nxt;
      if (bus.load) begin
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp_in;
        r_pend_vld <= 1'b1;
      end else if (w_commit) begin
        r_pend_vld <= 1'b0;
      end else begin
        r_pend_vld <= r_pend_vld;
      end
    end
  end

  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.frame_start = r_frame_start;

endmodule
